axi_write_scheduler: RTL and testbench

Sequencing controller for the shared write path of the multi-master AXI slave router. Round-robin arbitrates write-address requests from `PORT_NUM` upstream masters and drives the one-hot select of the AW mux. Records the order of accepted AW grants and locks the W mux to the oldest granted master until its WLAST beat completes. Enforces a per-port limit on writes awaiting a B response.

---
 rtl/axi_sched_pkg.sv | 30 +++
 rtl/axi_write_scheduler_grant_order_fifo.sv | 61 ++++++
 rtl/axi_write_scheduler.sv | 147 ++++++++++++++
 tb/tb_axi_write_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// Shared types and helpers for the AXI write scheduler: AW FSM state enum,
// constant clog2 and one-hot/index conversions (vectors up to 32 ports).
package axi_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } aw_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [31:0] idx_to_onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_write_scheduler_grant_order_fifo.sv
// grant_order_fifo: records AW grant indices in acceptance order so the W mux
// can follow them; registered count, full and empty.
module grant_order_fifo
  import axi_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= (32'(wr_ptr_q) == DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (32'(rd_ptr_q) == DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/axi_write_scheduler.sv
// Round-robin AW arbiter with in-order W locking and per-port outstanding cap.
// Optional same-cycle W bypass on an empty order queue: AXI_WSCHED_BYPASS_EN.
module axi_write_scheduler
  import axi_sched_pkg::*;
#(
  parameter int unsigned PORT_NUM        = 2,
  parameter int unsigned ORDER_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [PORT_NUM-1:0] aw_req_i,
  input  logic                aw_hs_i,
  output logic [PORT_NUM-1:0] aw_gnt_o,
  input  logic                w_hs_i,
  input  logic                w_last_i,
  output logic [PORT_NUM-1:0] w_gnt_o,
  input  logic [PORT_NUM-1:0] b_done_i,
  output logic                order_full_o,
  output logic                err_o
);

  localparam int unsigned IDX_W = (PORT_NUM > 1) ? clog2(PORT_NUM) : 1;
  localparam int unsigned CNT_W = clog2(MAX_OUTSTANDING + 1);

  aw_state_e           state_q, state_d;
  logic [PORT_NUM-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q [PORT_NUM];
  logic [PORT_NUM-1:0] eligible;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx, gnt_idx, head_idx;
  int unsigned         cand;
  logic                aw_push, bypass, wlast_hs;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                w_err, b_err, err_q;

  always_comb begin
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      eligible[p] = aw_req_i[p] && (cnt_q[p] != CNT_W'(MAX_OUTSTANDING));
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      cand = (32'(rr_ptr_q) + k) % PORT_NUM;
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign gnt_idx = IDX_W'(onehot_to_idx(32'(gnt_q)));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    aw_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found && !fifo_full) begin
          gnt_d   = PORT_NUM'(idx_to_onehot(32'(pick_idx)));
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (aw_hs_i) begin
          aw_push  = 1'b1;
          gnt_d    = '0;
          rr_ptr_d = IDX_W'((32'(gnt_idx) + 1) % PORT_NUM);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AXI_WSCHED_BYPASS_EN
  assign bypass = aw_push & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed grant whose WLAST lands in the same cycle is never queued.
  assign wlast_hs  = w_hs_i & w_last_i;
  assign fifo_push = aw_push & ~(bypass & wlast_hs);
  assign fifo_pop  = wlast_hs & ~fifo_empty;
  assign w_err     = w_hs_i & fifo_empty & ~bypass;

  grant_order_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (IDX_W)
  ) u_order (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (fifo_push),
    .din   (gnt_idx),
    .pop   (fifo_pop),
    .dout  (head_idx),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    b_err = 1'b0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (b_done_i[p] && !(aw_push && gnt_q[p]) && cnt_q[p] == '0) b_err = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) cnt_q[p] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (aw_push && gnt_q[p] && !b_done_i[p])                cnt_q[p] <= cnt_q[p] + 1'b1;
        else if (b_done_i[p] && !(aw_push && gnt_q[p]) && cnt_q[p] != '0) cnt_q[p] <= cnt_q[p] - 1'b1;
      end
      err_q <= err_q | w_err | b_err;
    end
  end

  assign aw_gnt_o     = gnt_q;
  assign w_gnt_o      = fifo_empty ? (bypass ? gnt_q : '0)
                                   : PORT_NUM'(idx_to_onehot(32'(head_idx)));
  assign order_full_o = fifo_full;
  assign err_o        = err_q;

endmodule

// File: tb/tb_axi_write_scheduler.sv
// Randomized bench for axi_write_scheduler against a queue-based reference model.
module tb_axi_write_scheduler;

  localparam int unsigned PORT_NUM        = 2;
  localparam int unsigned ORDER_DEPTH     = 4;
  localparam int unsigned MAX_OUTSTANDING = 8;
`ifdef AXI_WSCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic [PORT_NUM-1:0] aw_req;
  logic                aw_hs;
  logic [PORT_NUM-1:0] aw_gnt;
  logic                w_hs;
  logic                w_last;
  logic [PORT_NUM-1:0] w_gnt;
  logic [PORT_NUM-1:0] b_done;
  logic                order_full;
  logic                err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state: pending grant (-1 = none), rr pointer, order queue, counters.
  int pend;
  int rr;
  int q[$];
  int cnt[PORT_NUM];
  bit m_err;

  always #5 ACLK = ~ACLK;

  axi_write_scheduler #(
    .PORT_NUM        (PORT_NUM),
    .ORDER_DEPTH     (ORDER_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .aw_req_i     (aw_req),
    .aw_hs_i      (aw_hs),
    .aw_gnt_o     (aw_gnt),
    .w_hs_i       (w_hs),
    .w_last_i     (w_last),
    .w_gnt_o      (w_gnt),
    .b_done_i     (b_done),
    .order_full_o (order_full),
    .err_o        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot(input int idx);
    return (idx < 0) ? 32'd0 : (32'd1 << idx);
  endfunction

  task automatic model_reset();
    pend = -1;
    rr   = 0;
    q.delete();
    for (int p = 0; p < PORT_NUM; p++) cnt[p] = 0;
    m_err = 1'b0;
  endtask

  function automatic bit bypass_now();
    return BYP && pend >= 0 && aw_hs && q.size() == 0;
  endfunction

  task automatic model_step();
    int  new_pend, new_rr;
    bit  byp, wl, pushed;
    if (!ARESETN) begin
      model_reset();
      return;
    end
    wl       = w_hs && w_last;
    byp      = bypass_now();
    pushed   = pend >= 0 && aw_hs;
    new_pend = pend;
    new_rr   = rr;
    if (pend >= 0) begin
      if (aw_hs) begin
        new_rr   = (pend + 1) % PORT_NUM;
        new_pend = -1;
      end
    end else if (q.size() < ORDER_DEPTH) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        int c = (rr + k) % PORT_NUM;
        if (aw_req[c] && cnt[c] < MAX_OUTSTANDING) begin
          new_pend = c;
          break;
        end
      end
    end
    if (w_hs && q.size() == 0 && !byp) m_err = 1'b1;
    if (wl && q.size() > 0) void'(q.pop_front());
    if (pushed && !(byp && wl)) q.push_back(pend);
    for (int p = 0; p < PORT_NUM; p++) begin
      bit inc = pushed && pend == p;
      if (inc && !b_done[p]) cnt[p]++;
      else if (b_done[p] && !inc) begin
        if (cnt[p] == 0) m_err = 1'b1;
        else cnt[p]--;
      end
    end
    pend = new_pend;
    rr   = new_rr;
  endtask

  // Inputs are set at the falling edge; outputs are checked 1ns later.
  task automatic tick();
    logic [31:0] exp_w;
    #1;
    exp_w = (q.size() > 0) ? onehot(q[0]) : (bypass_now() ? onehot(pend) : 32'd0);
    check_eq("aw_gnt", 32'(aw_gnt), onehot(pend));
    check_eq("w_gnt", 32'(w_gnt), exp_w);
    check_eq("order_full", 32'(order_full), 32'(q.size() == ORDER_DEPTH));
    check_eq("err", 32'(err), 32'(m_err));
    @(posedge ACLK);
    model_step();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    aw_req = '0; aw_hs = 1'b0; w_hs = 1'b0; w_last = 1'b0; b_done = '0;
  endtask

  task automatic do_reset(input int n);
    ARESETN = 1'b0;
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
    ARESETN = 1'b1;
  endtask

  task automatic random_phase(input int cycles, input logic [PORT_NUM-1:0] mask,
                              input int p_aw, input int p_w, input int p_last, input int p_b);
    for (int i = 0; i < cycles; i++) begin
      aw_req = PORT_NUM'($urandom) & mask;
      aw_hs  = ($urandom_range(99) < p_aw);
      w_hs   = (q.size() > 0 || bypass_now()) && ($urandom_range(99) < p_w);
      w_last = ($urandom_range(99) < p_last);
      for (int p = 0; p < PORT_NUM; p++)
        b_done[p] = (cnt[p] > 0) && ($urandom_range(99) < p_b);
      tick();
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge ACLK);
    @(negedge ACLK);
    do_reset(2);

    random_phase(300, '1, 100, 60, 50, 40);
    random_phase(20, '1, 100, 0, 0, 30);
    check_eq("full_after_fill", 32'(order_full), 32'd1);
    random_phase(12, '1, 100, 100, 100, 30);
    random_phase(80, 2'b01, 100, 80, 100, 0);
    random_phase(40, '1, 100, 80, 100, 0);
    random_phase(60, '1, 100, 80, 100, 50);
    random_phase(400, '1, 70, 50, 40, 30);

    random_phase(30, '1, 100, 90, 25, 30);
    ARESETN = 1'b0;
    w_hs = 1'b1; w_last = 1'b0;
    tick();
    ARESETN = 1'b1;
    idle_inputs();
    tick();
    check_eq("rst_mid_burst_wgnt", 32'(w_gnt), 32'd0);

    b_done = 2'b10;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    check_eq("err_b_underflow", 32'(err), 32'd1);

    do_reset(1);
    w_hs = 1'b1; w_last = 1'b1;
    tick();
    idle_inputs();
    random_phase(20, '1, 100, 60, 50, 40);
    check_eq("err_w_empty_sticky", 32'(err), 32'd1);

    do_reset(1);
    random_phase(200, '1, 80, 60, 50, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
